// File: rtl/ysyx_24120013_pkg.sv
// Shared types and constants for the NPC multi-cycle controller.
// Holds the sequencer state encoding, the halt-cause codes and the default boot PC.
package ysyx_24120013_pkg;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      HALT
   } state_t;

   localparam logic [1:0] HALT_EBREAK  = 2'd0;
   localparam logic [1:0] HALT_ILLEGAL = 2'd1;
   localparam logic [1:0] HALT_TIMEOUT = 2'd2;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_24120013_wait_timer.sv
// Handshake wait timer: counts enabled cycles and flags the TIMEOUT-th cycle without a response.
// The count returns to zero whenever the wait ends or the timer is disabled.
module ysyx_24120013_wait_timer #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear || !enable) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   // The first waiting cycle sees count 0, so LIMIT marks the TIMEOUT-th cycle.
   assign expire = enable && !clear && (count == LIMIT);

endmodule

// File: rtl/ysyx_24120013_core_ctrl.sv
// NPC multi-cycle sequencer: FETCH, DECODE, EXEC, MEM, WB with sticky halt.
// Owns PC and the instruction register and keeps the cycle and instret counters.
module ysyx_24120013_core_ctrl
   import ysyx_24120013_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC),
   parameter int unsigned TIMEOUT    = 1024,
   parameter int unsigned CNT_WIDTH  = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  ifu_req,
   output logic [ADDR_WIDTH-1:0] ifu_pc,
   input  logic                  ifu_ack,
   input  logic [DATA_WIDTH-1:0] ifu_inst,
   output logic [DATA_WIDTH-1:0] inst,
   input  logic                  idu_is_mem,
   input  logic                  idu_ebreak,
   input  logic                  idu_illegal,
   output logic                  exu_start,
   input  logic                  exu_done,
   input  logic                  exu_wen,
   input  logic [ADDR_WIDTH-1:0] exu_next_pc,
   output logic                  lsu_req,
   input  logic                  lsu_ack,
   output logic                  rf_commit,
   output logic                  halt,
   output logic [1:0]            halt_code,
   output logic [CNT_WIDTH-1:0]  cycle_cnt,
   output logic [CNT_WIDTH-1:0]  instret_cnt
);

   state_t                state;
   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] next_pc_q;
   logic                  wen_q;
   logic                  wait_en;
   logic                  wait_done;
   logic                  expire;

   assign ifu_pc  = pc;
   assign ifu_req = (state == FETCH);
   assign lsu_req = (state == MEM);

   assign wait_en   = (state == FETCH) || (state == EXEC) || (state == MEM);
   assign wait_done = ((state == FETCH) && ifu_ack) ||
                      ((state == EXEC)  && exu_done) ||
                      ((state == MEM)   && lsu_ack);

   ysyx_24120013_wait_timer #(
      .TIMEOUT(TIMEOUT)
   ) u_wait_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (wait_done),
      .enable(wait_en),
      .expire(expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         next_pc_q   <= RESET_PC;
         wen_q       <= 1'b0;
         inst        <= '0;
         exu_start   <= 1'b0;
         rf_commit   <= 1'b0;
         halt        <= 1'b0;
         halt_code   <= HALT_EBREAK;
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         exu_start <= 1'b0;
         rf_commit <= 1'b0;
         if (state != HALT) begin
            cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
         end
         case (state)
            FETCH: begin
               if (ifu_ack) begin
                  inst  <= ifu_inst;
                  state <= DECODE;
               end else if (expire) begin
                  state     <= HALT;
                  halt      <= 1'b1;
                  halt_code <= HALT_TIMEOUT;
               end
            end
            DECODE: begin
               if (idu_illegal) begin
                  state     <= HALT;
                  halt      <= 1'b1;
                  halt_code <= HALT_ILLEGAL;
               end else if (idu_ebreak) begin
                  state     <= HALT;
                  halt      <= 1'b1;
                  halt_code <= HALT_EBREAK;
               end else begin
                  state     <= EXEC;
                  exu_start <= 1'b1;
               end
            end
            EXEC: begin
               if (exu_done) begin
                  wen_q     <= exu_wen;
                  next_pc_q <= exu_next_pc;
                  if (idu_is_mem) begin
                     state <= MEM;
                  end else begin
                     // rf_commit is loaded on WB entry so it is a clean register output.
                     state     <= WB;
                     rf_commit <= exu_wen;
                  end
               end else if (expire) begin
                  state     <= HALT;
                  halt      <= 1'b1;
                  halt_code <= HALT_TIMEOUT;
               end
            end
            MEM: begin
               if (lsu_ack) begin
                  state     <= WB;
                  rf_commit <= wen_q;
               end else if (expire) begin
                  state     <= HALT;
                  halt      <= 1'b1;
                  halt_code <= HALT_TIMEOUT;
               end
            end
            WB: begin
               pc          <= next_pc_q;
               instret_cnt <= instret_cnt + CNT_WIDTH'(1);
               state       <= FETCH;
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_24120013_core_ctrl.sv
// Self-checking bench for the NPC multi-cycle controller.
// Open-loop environment: per-instruction latencies define the expected per-cycle handshake pattern.
module tb_ysyx_24120013_core_ctrl;
   import ysyx_24120013_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 64;
   localparam int unsigned TO = 8;
   localparam logic [AW-1:0] BOOT_PC = 32'h8000_0000;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ifu_req;
   logic [AW-1:0] ifu_pc;
   logic          ifu_ack = 1'b0;
   logic [DW-1:0] ifu_inst = '0;
   logic [DW-1:0] inst;
   logic          idu_is_mem = 1'b0;
   logic          idu_ebreak = 1'b0;
   logic          idu_illegal = 1'b0;
   logic          exu_start;
   logic          exu_done = 1'b0;
   logic          exu_wen = 1'b0;
   logic [AW-1:0] exu_next_pc = '0;
   logic          lsu_req;
   logic          lsu_ack = 1'b0;
   logic          rf_commit;
   logic          halt;
   logic [1:0]    halt_code;
   logic [CW-1:0] cycle_cnt;
   logic [CW-1:0] instret_cnt;

   always #5 clk = ~clk;

   ysyx_24120013_core_ctrl #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .RESET_PC  (BOOT_PC),
      .TIMEOUT   (TO),
      .CNT_WIDTH (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ifu_req    (ifu_req),
      .ifu_pc     (ifu_pc),
      .ifu_ack    (ifu_ack),
      .ifu_inst   (ifu_inst),
      .inst       (inst),
      .idu_is_mem (idu_is_mem),
      .idu_ebreak (idu_ebreak),
      .idu_illegal(idu_illegal),
      .exu_start  (exu_start),
      .exu_done   (exu_done),
      .exu_wen    (exu_wen),
      .exu_next_pc(exu_next_pc),
      .lsu_req    (lsu_req),
      .lsu_ack    (lsu_ack),
      .rf_commit  (rf_commit),
      .halt       (halt),
      .halt_code  (halt_code),
      .cycle_cnt  (cycle_cnt),
      .instret_cnt(instret_cnt)
   );

   typedef struct {
      int unsigned   fw;
      int unsigned   ew;
      int unsigned   mw;
      logic          is_mem;
      logic          wen;
      logic [AW-1:0] npc;
      logic [DW-1:0] iw;
      int unsigned   exp_cycles;
   } vec_t;

   int checks = 0;
   int failures = 0;

   // Architectural model: expected PC, IR, counters.
   logic [AW-1:0] m_pc;
   logic [DW-1:0] m_inst;
   logic [CW-1:0] m_cycles;
   logic [CW-1:0] m_instret;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive_noise();
      ifu_ack     = 1'($urandom_range(0, 1));
      ifu_inst    = $urandom;
      idu_is_mem  = 1'($urandom_range(0, 1));
      idu_ebreak  = 1'($urandom_range(0, 1));
      idu_illegal = 1'($urandom_range(0, 1));
      exu_done    = 1'($urandom_range(0, 1));
      exu_wen     = 1'($urandom_range(0, 1));
      exu_next_pc = $urandom;
      lsu_ack     = 1'($urandom_range(0, 1));
   endtask

   task automatic quiet_inputs();
      ifu_ack = 0; ifu_inst = '0; idu_is_mem = 0; idu_ebreak = 0; idu_illegal = 0;
      exu_done = 0; exu_wen = 0; exu_next_pc = '0; lsu_ack = 0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      quiet_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_pc = BOOT_PC; m_inst = '0; m_cycles = '0; m_instret = '0;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, " ifu_req"},   64'(ifu_req),   64'(1));
      chk({tag, " pc"},        64'(ifu_pc),    64'(BOOT_PC));
      chk({tag, " inst"},      64'(inst),      64'(0));
      chk({tag, " halt"},      64'(halt),      64'(0));
      chk({tag, " halt_code"}, 64'(halt_code), 64'(0));
      chk({tag, " exu_start"}, 64'(exu_start), 64'(0));
      chk({tag, " lsu_req"},   64'(lsu_req),   64'(0));
      chk({tag, " rf_commit"}, 64'(rf_commit), 64'(0));
      chk({tag, " cycle_cnt"}, cycle_cnt,      64'(0));
      chk({tag, " instret"},   instret_cnt,    64'(0));
   endtask

   // Checks one running cycle at the negedge, then randomises every input.
   task automatic cycle_begin(input logic e_ifu, input logic e_exs, input logic e_lsu,
                              input logic e_rfc, input string tag);
      chk({tag, " ifu_req"},   64'(ifu_req),   64'(e_ifu));
      chk({tag, " exu_start"}, 64'(exu_start), 64'(e_exs));
      chk({tag, " lsu_req"},   64'(lsu_req),   64'(e_lsu));
      chk({tag, " rf_commit"}, 64'(rf_commit), 64'(e_rfc));
      chk({tag, " ifu_pc"},    64'(ifu_pc),    64'(m_pc));
      chk({tag, " halt"},      64'(halt),      64'(0));
      chk({tag, " cycle_cnt"}, cycle_cnt,      m_cycles);
      chk({tag, " instret"},   instret_cnt,    m_instret);
      m_cycles++;
      drive_noise();
   endtask

   task automatic halt_check(input logic [1:0] code, input int unsigned n, input string tag);
      for (int unsigned i = 0; i < n; i++) begin
         chk({tag, " halt"},      64'(halt),      64'(1));
         chk({tag, " halt_code"}, 64'(halt_code), 64'(code));
         chk({tag, " ifu_req"},   64'(ifu_req),   64'(0));
         chk({tag, " exu_start"}, 64'(exu_start), 64'(0));
         chk({tag, " lsu_req"},   64'(lsu_req),   64'(0));
         chk({tag, " rf_commit"}, 64'(rf_commit), 64'(0));
         chk({tag, " cycle_cnt"}, cycle_cnt,      m_cycles);
         chk({tag, " instret"},   instret_cnt,    m_instret);
         chk({tag, " pc"},        64'(ifu_pc),    64'(m_pc));
         chk({tag, " inst"},      64'(inst),      64'(m_inst));
         drive_noise();
         @(negedge clk);
      end
   endtask

   task automatic do_fetch(input int unsigned fw, input logic [DW-1:0] iw);
      for (int unsigned i = 0; i <= fw; i++) begin
         cycle_begin(1, 0, 0, 0, "fetch");
         ifu_ack = (i == fw);
         if (i == fw) ifu_inst = iw;
         @(negedge clk);
      end
      m_inst = iw;
   endtask

   task automatic do_decode(input logic [DW-1:0] iw, input logic is_mem,
                            input logic ill, input logic ebr);
      cycle_begin(0, 0, 0, 0, "decode");
      chk("decode inst", 64'(inst), 64'(iw));
      idu_illegal = ill;
      idu_ebreak  = ebr;
      idu_is_mem  = is_mem;
      @(negedge clk);
   endtask

   task automatic run_instr(input int unsigned fw, input int unsigned ew, input int unsigned mw,
                            input logic is_mem, input logic wen,
                            input logic [AW-1:0] npc, input logic [DW-1:0] iw);
      do_fetch(fw, iw);
      do_decode(iw, is_mem, 0, 0);
      for (int unsigned i = 0; i <= ew; i++) begin
         cycle_begin(0, (i == 0), 0, 0, "exec");
         idu_is_mem = is_mem;
         exu_done   = (i == ew);
         if (i == ew) begin
            exu_wen     = wen;
            exu_next_pc = npc;
         end
         @(negedge clk);
      end
      if (is_mem) begin
         for (int unsigned i = 0; i <= mw; i++) begin
            cycle_begin(0, 0, 1, 0, "mem");
            lsu_ack = (i == mw);
            @(negedge clk);
         end
      end
      cycle_begin(0, 0, 0, wen, "wb");
      @(negedge clk);
      m_pc = npc;
      m_instret++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t          tbl[6];
      logic [CW-1:0] start;

      tbl[0] = '{0, 0, 0, 1'b0, 1'b1, 32'h8000_0004, 32'h0010_0093, 4};
      tbl[1] = '{0, 0, 3, 1'b1, 1'b1, 32'h8000_0008, 32'h0000_a103, 8};
      tbl[2] = '{2, 1, 0, 1'b0, 1'b0, 32'h8000_0100, 32'h0f00_006f, 7};
      tbl[3] = '{7, 0, 0, 1'b0, 1'b1, 32'h8000_0104, 32'h0020_8133, 11};
      tbl[4] = '{0, 7, 0, 1'b0, 1'b1, 32'h8000_0108, 32'h4020_81b3, 11};
      tbl[5] = '{1, 2, 7, 1'b1, 1'b0, 32'h8000_010c, 32'h0031_2023, 15};

      #2;
      apply_reset();
      check_reset_state("reset");

      for (int unsigned k = 0; k < 6; k++) begin
         start = m_cycles;
         run_instr(tbl[k].fw, tbl[k].ew, tbl[k].mw, tbl[k].is_mem, tbl[k].wen, tbl[k].npc, tbl[k].iw);
         chk($sformatf("tbl%0d cycles", k), cycle_cnt, start + 64'(tbl[k].exp_cycles));
         chk($sformatf("tbl%0d instret", k), instret_cnt, 64'(k + 1));
         chk($sformatf("tbl%0d pc", k), 64'(ifu_pc), 64'(tbl[k].npc));
      end

      for (int unsigned k = 0; k < 40; k++) begin
         run_instr($urandom_range(0, TO - 1), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom & 32'hFFFF_FFFC, $urandom);
      end

      // Illegal has priority over ebreak; no EXEC entry afterwards.
      apply_reset();
      do_fetch(0, 32'hDEAD_BEEF);
      do_decode(32'hDEAD_BEEF, 0, 1, 1);
      halt_check(HALT_ILLEGAL, 5, "illegal");

      apply_reset();
      run_instr(0, 0, 0, 0, 1, 32'h8000_0004, 32'h0010_0093);
      do_fetch(1, 32'h0010_0073);
      do_decode(32'h0010_0073, 0, 0, 1);
      halt_check(HALT_EBREAK, 4, "ebreak");

      apply_reset();
      for (int unsigned i = 0; i < TO; i++) begin
         cycle_begin(1, 0, 0, 0, "fetch_to");
         ifu_ack = 0;
         @(negedge clk);
      end
      halt_check(HALT_TIMEOUT, 4, "fetch_timeout");

      apply_reset();
      do_fetch(0, 32'h0000_0013);
      do_decode(32'h0000_0013, 0, 0, 0);
      for (int unsigned i = 0; i < TO; i++) begin
         cycle_begin(0, (i == 0), 0, 0, "exec_to");
         exu_done = 0;
         @(negedge clk);
      end
      halt_check(HALT_TIMEOUT, 3, "exec_timeout");

      apply_reset();
      do_fetch(0, 32'h0000_a103);
      do_decode(32'h0000_a103, 1, 0, 0);
      cycle_begin(0, 1, 0, 0, "exec_m");
      idu_is_mem = 1; exu_done = 1; exu_wen = 1; exu_next_pc = 32'h8000_0004;
      @(negedge clk);
      for (int unsigned i = 0; i < TO; i++) begin
         cycle_begin(0, 0, 1, 0, "mem_to");
         lsu_ack = 0;
         @(negedge clk);
      end
      halt_check(HALT_TIMEOUT, 3, "mem_timeout");

      // Reset in the middle of a memory wait, with non-zero counters beforehand.
      apply_reset();
      run_instr(0, 0, 0, 0, 1, 32'h8000_0040, 32'h0010_0093);
      do_fetch(0, 32'h0000_a103);
      do_decode(32'h0000_a103, 1, 0, 0);
      cycle_begin(0, 1, 0, 0, "exec_r");
      idu_is_mem = 1; exu_done = 1; exu_wen = 1; exu_next_pc = 32'h8000_0044;
      @(negedge clk);
      for (int unsigned i = 0; i < 2; i++) begin
         cycle_begin(0, 0, 1, 0, "mem_r");
         lsu_ack = 0;
         @(negedge clk);
      end
      chk("pre-reset lsu_req", 64'(lsu_req), 64'(1));
      #2 rst = 1'b1;
      #1;
      chk("midrst lsu_req", 64'(lsu_req), 64'(0));
      chk("midrst ifu_req", 64'(ifu_req), 64'(1));
      chk("midrst pc", 64'(ifu_pc), 64'(BOOT_PC));
      chk("midrst cycle_cnt", cycle_cnt, 64'(0));
      chk("midrst instret", instret_cnt, 64'(0));
      chk("midrst halt", 64'(halt), 64'(0));
      apply_reset();
      check_reset_state("post_rst");
      run_instr(0, 0, 0, 0, 1, 32'h8000_0004, 32'h0010_0093);
      chk("post_rst instret", instret_cnt, 64'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
